// File: rtl/fixed_point_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_bcd_display
// Purpose  : Sequential fixed-point to decimal converter with seven-segment
//            drive. Integer part via iterative double-dabble, fraction part
//            via repeated multiply-by-10 (truncating). Results held in
//            registers until the next conversion completes.
// Options  : LEADING_ZERO_BLANK_EN - blank integer digits above the most
//            significant nonzero integer digit (ones digit never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module fixed_point_bcd_display #(
    parameter int INT_W       = 10,
    parameter int FRAC_W      = 6,
    parameter int INT_DIGITS  = 4,
    parameter int FRAC_DIGITS = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [INT_W-1:0]                          int_in,
    input  logic [FRAC_W-1:0]                         frac_in,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      overflow,
    output logic [4*(INT_DIGITS+FRAC_DIGITS)-1:0]     digits_out,
    output logic [7*(INT_DIGITS+FRAC_DIGITS)-1:0]     seg_out
);

    localparam int c_NDIG   = INT_DIGITS + FRAC_DIGITS;
    localparam int c_BCD_W  = 4 * (INT_DIGITS + 1);
    localparam int c_FDIG_W = 4 * FRAC_DIGITS;
    localparam int c_STEPS  = (INT_W > FRAC_DIGITS) ? INT_W : FRAC_DIGITS;
    localparam int c_CNT_W  = $clog2(c_STEPS + 1);

    // Largest integer representable in INT_DIGITS decimal digits
    function automatic logic [63:0] f_max_value(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam logic [63:0] c_INT_MAX = f_max_value(INT_DIGITS);

    // Active-low {g,f,e,d,c,b,a} decode of one BCD digit
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INT  = 2'd1,
        S_FRAC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [INT_W-1:0]        r_int_sh;
    logic [c_BCD_W-1:0]      r_bcd;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [FRAC_W-1:0]       r_frac;
    logic [c_FDIG_W-1:0]     r_fdig;
    logic                    r_ovf_next;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_ovf;
    logic [4*c_NDIG-1:0]     r_digits;

    logic [c_BCD_W-1:0]      w_bcd_adj;
    logic [c_BCD_W:0]        w_bcd_wide;
    logic [FRAC_W+3:0]       w_prod;
    logic [c_FDIG_W+3:0]     w_fdig_wide;
    logic [4*INT_DIGITS-1:0] w_int_digits;
    logic                    w_ovf_in;

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < INT_DIGITS + 1; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_wide   = {w_bcd_adj, r_int_sh[INT_W-1]};
    assign w_prod       = (FRAC_W+4)'(r_frac) * (FRAC_W+4)'(4'd10);
    assign w_fdig_wide  = {r_fdig, w_prod[FRAC_W+3:FRAC_W]};
    assign w_int_digits = r_ovf_next ? {INT_DIGITS{4'h9}} : r_bcd[4*INT_DIGITS-1:0];
    assign w_ovf_in     = (64'(int_in) > c_INT_MAX);

    // Conversion sequencer: latch, integer steps, fraction steps, publish
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_int_sh   <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_frac     <= '0;
            r_fdig     <= '0;
            r_ovf_next <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_digits   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_int_sh   <= int_in;
                        r_frac     <= frac_in;
                        r_bcd      <= '0;
                        r_fdig     <= '0;
                        r_cnt      <= '0;
                        r_ovf_next <= w_ovf_in;
                        r_busy     <= 1'b1;
                        r_state    <= S_INT;
                    end
                end
                S_INT: begin
                    r_bcd    <= w_bcd_wide[c_BCD_W-1:0];
                    r_int_sh <= r_int_sh << 1;
                    if (r_cnt == c_CNT_W'(INT_W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_FRAC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FRAC: begin
                    r_frac <= w_prod[FRAC_W-1:0];
                    r_fdig <= w_fdig_wide[c_FDIG_W-1:0];
                    if (r_cnt == c_CNT_W'(FRAC_DIGITS - 1)) begin
                        r_cnt    <= '0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_ovf    <= r_ovf_next;
                        r_digits <= {w_int_digits, w_fdig_wide[c_FDIG_W-1:0]};
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_ovf;
    assign digits_out = r_digits;

    // Segment decode of the held digits, with optional leading-zero blanking
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic w_lead_zero;
        w_lead_zero = 1'b1;
`endif
        seg_out = '0;
        for (int d = c_NDIG - 1; d >= 0; d--) begin
            seg_out[d*7 +: 7] = f_seg(r_digits[d*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (d > FRAC_DIGITS) begin
                w_lead_zero = w_lead_zero & (r_digits[d*4 +: 4] == 4'd0);
                if (w_lead_zero) begin
                    seg_out[d*7 +: 7] = 7'b1111111;
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_bcd_display.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fixed_point_bcd_display
// Purpose  : Scoreboard bench for fixed_point_bcd_display: default build,
//            a 3-integer-digit overflow build and a 16.8 / 5.3 wide build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_point_bcd_display;

    localparam int c_L    = 12;
    localparam int c_L_WD = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default build
    logic        main_start = 1'b0;
    logic [9:0]  main_int   = '0;
    logic [5:0]  main_frac  = '0;
    logic        main_busy, main_done, main_ovf;
    logic [23:0] main_dig;
    logic [41:0] main_seg;
    // three integer digits
    logic        ov_start = 1'b0;
    logic [9:0]  ov_int   = '0;
    logic [5:0]  ov_frac  = '0;
    logic        ov_busy, ov_done, ov_ovf;
    logic [19:0] ov_dig;
    logic [34:0] ov_seg;
    // wide build
    logic        wd_start = 1'b0;
    logic [15:0] wd_int   = '0;
    logic [7:0]  wd_frac  = '0;
    logic        wd_busy, wd_done, wd_ovf;
    logic [31:0] wd_dig;
    logic [55:0] wd_seg;

    fixed_point_bcd_display u_main (
        .clk(clk), .rst(rst), .start(main_start), .int_in(main_int), .frac_in(main_frac),
        .busy(main_busy), .done(main_done), .overflow(main_ovf),
        .digits_out(main_dig), .seg_out(main_seg)
    );

    fixed_point_bcd_display #(.INT_W(10), .FRAC_W(6), .INT_DIGITS(3), .FRAC_DIGITS(2)) u_ov (
        .clk(clk), .rst(rst), .start(ov_start), .int_in(ov_int), .frac_in(ov_frac),
        .busy(ov_busy), .done(ov_done), .overflow(ov_ovf),
        .digits_out(ov_dig), .seg_out(ov_seg)
    );

    fixed_point_bcd_display #(.INT_W(16), .FRAC_W(8), .INT_DIGITS(5), .FRAC_DIGITS(3)) u_wd (
        .clk(clk), .rst(rst), .start(wd_start), .int_in(wd_int), .frac_in(wd_frac),
        .busy(wd_busy), .done(wd_done), .overflow(wd_ovf),
        .digits_out(wd_dig), .seg_out(wd_seg)
    );

    typedef struct {
        logic [63:0] dig;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q_main[$];
    exp_t q_ov[$];
    exp_t q_wd[$];

    logic [63:0] main_exp_dig = '0;
    logic        main_exp_ovf = 1'b0;
    logic [63:0] ov_exp_dig   = '0;
    logic        ov_exp_ovf   = 1'b0;
    logic [63:0] wd_exp_dig   = '0;
    logic        wd_exp_ovf   = 1'b0;

    int cyc       = 0;
    int free_main = 0;
    int free_ov   = 0;
    int free_wd   = 0;
    int tests     = 0;
    int fails     = 0;

    task automatic chk(input string nm, input logic [111:0] act, input logic [111:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;  4'd1: seg7 = 7'h79;  4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;  4'd4: seg7 = 7'h19;  4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;  4'd7: seg7 = 7'h78;  4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;  default: seg7 = 7'h7f;
        endcase
    endfunction

    // Expected display pattern for a digit string
    function automatic logic [111:0] exp_seg(input logic [63:0] dig, input int ndig, input int nfrac);
        logic [111:0] r;
        logic [3:0]   nib;
        logic [6:0]   s;
        logic         lz;
        r  = '0;
        lz = 1'b1;
        for (int d = ndig - 1; d >= 0; d--) begin
            nib = dig[d*4 +: 4];
            s   = seg7(nib);
`ifdef LEADING_ZERO_BLANK_EN
            if (d > nfrac) begin
                lz = lz && (nib == 4'd0);
                if (lz) s = 7'h7f;
            end
`else
            lz = lz && (nfrac >= 0);
`endif
            r[d*7 +: 7] = s;
        end
        return r;
    endfunction

    // Stimulus-side model: a start seen while the model is idle is accepted
    always @(posedge clk) begin
        if (!rst) begin
            q_main.delete();
            q_ov.delete();
            q_wd.delete();
            free_main = 0;
            free_ov   = 0;
            free_wd   = 0;
        end else begin
            if (main_start && cyc >= free_main) begin
                q_main.push_back('{dig: main_exp_dig, ovf: main_exp_ovf, cyc: cyc + c_L + 1});
                free_main = cyc + c_L + 2;
            end
            if (ov_start && cyc >= free_ov) begin
                q_ov.push_back('{dig: ov_exp_dig, ovf: ov_exp_ovf, cyc: cyc + c_L + 1});
                free_ov = cyc + c_L + 2;
            end
            if (wd_start && cyc >= free_wd) begin
                q_wd.push_back('{dig: wd_exp_dig, ovf: wd_exp_ovf, cyc: cyc + c_L_WD + 1});
                free_wd = cyc + c_L_WD + 2;
            end
        end
        cyc++;
    end

    // Monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        exp_t e;
        if (main_done) begin
            if (q_main.size() == 0) begin
                chk("main_unexpected_done", 112'(1), 112'(0));
            end else begin
                e = q_main.pop_front();
                chk("main_digits", 112'(main_dig), 112'(e.dig));
                chk("main_seg", 112'(main_seg), exp_seg(e.dig, 6, 2));
                chk("main_overflow", 112'(main_ovf), 112'(e.ovf));
                chk("main_done_cycle", 112'(cyc), 112'(e.cyc));
                chk("main_busy_at_done", 112'(main_busy), 112'(0));
            end
        end
        if (ov_done) begin
            if (q_ov.size() == 0) begin
                chk("ov_unexpected_done", 112'(1), 112'(0));
            end else begin
                e = q_ov.pop_front();
                chk("ov_digits", 112'(ov_dig), 112'(e.dig));
                chk("ov_seg", 112'(ov_seg), exp_seg(e.dig, 5, 2));
                chk("ov_overflow", 112'(ov_ovf), 112'(e.ovf));
                chk("ov_done_cycle", 112'(cyc), 112'(e.cyc));
            end
        end
        if (wd_done) begin
            if (q_wd.size() == 0) begin
                chk("wd_unexpected_done", 112'(1), 112'(0));
            end else begin
                e = q_wd.pop_front();
                chk("wd_digits", 112'(wd_dig), 112'(e.dig));
                chk("wd_seg", 112'(wd_seg), exp_seg(e.dig, 8, 3));
                chk("wd_overflow", 112'(wd_ovf), 112'(e.ovf));
                chk("wd_done_cycle", 112'(cyc), 112'(e.cyc));
            end
        end
    end

    task automatic go_main(input logic [15:0] iv, input logic [7:0] fv,
                           input logic [63:0] ed, input logic eo);
        @(posedge clk); #1;
        main_int = iv[9:0]; main_frac = fv[5:0];
        main_exp_dig = ed; main_exp_ovf = eo; main_start = 1'b1;
        @(posedge clk); #1;
        main_start = 1'b0;
        repeat (c_L + 2) @(posedge clk);
    endtask

    task automatic go_ov(input logic [15:0] iv, input logic [7:0] fv,
                         input logic [63:0] ed, input logic eo);
        @(posedge clk); #1;
        ov_int = iv[9:0]; ov_frac = fv[5:0];
        ov_exp_dig = ed; ov_exp_ovf = eo; ov_start = 1'b1;
        @(posedge clk); #1;
        ov_start = 1'b0;
        repeat (c_L + 2) @(posedge clk);
    endtask

    task automatic go_wd(input logic [15:0] iv, input logic [7:0] fv,
                         input logic [63:0] ed, input logic eo);
        @(posedge clk); #1;
        wd_int = iv; wd_frac = fv;
        wd_exp_dig = ed; wd_exp_ovf = eo; wd_start = 1'b1;
        @(posedge clk); #1;
        wd_start = 1'b0;
        repeat (c_L_WD + 2) @(posedge clk);
    endtask

    task automatic set_main(input logic [9:0] iv, input logic [5:0] fv, input logic [63:0] ed);
        main_int = iv; main_frac = fv; main_exp_dig = ed; main_exp_ovf = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        #20;
        chk("rst_busy", 112'(main_busy), 112'(0));
        chk("rst_done", 112'(main_done), 112'(0));
        chk("rst_overflow", 112'(main_ovf), 112'(0));
        chk("rst_digits", 112'(main_dig), 112'(0));
        chk("rst_seg", 112'(main_seg), exp_seg(64'h0, 6, 2));
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        go_main(16'd1023, 8'd32, 64'h102350, 1'b0);
        go_wd(16'd65535, 8'd255, 64'h65535996, 1'b0);
        go_ov(16'd1023, 8'd0, 64'h99900, 1'b1);
        go_ov(16'd5, 8'd0, 64'h00500, 1'b0);
        go_main(16'd0, 8'd1, 64'h000001, 1'b0);
        go_main(16'd0, 8'd63, 64'h000098, 1'b0);

        // start held for 20 cycles while inputs keep changing
        @(posedge clk); #1;
        set_main(10'd321, 6'd16, 64'h032125);
        main_start = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_accept", 112'(main_busy), 112'(1));
        set_main(10'd999, 6'd63, 64'h099998);
        repeat (13) @(posedge clk);
        #1 set_main(10'd45, 6'd8, 64'h004512);
        @(posedge clk); #1;
        set_main(10'd888, 6'd1, 64'h088801);
        repeat (5) @(posedge clk);
        #1 main_start = 1'b0;
        repeat (12) @(posedge clk);

        // reset during the fraction phase of 777.75
        @(posedge clk); #1;
        set_main(10'd777, 6'd48, 64'h077775);
        main_start = 1'b1;
        @(posedge clk); #1;
        main_start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", 112'(main_busy), 112'(0));
        chk("abort_done", 112'(main_done), 112'(0));
        chk("abort_overflow", 112'(main_ovf), 112'(0));
        chk("abort_digits", 112'(main_dig), 112'(0));
        chk("abort_seg", 112'(main_seg), exp_seg(64'h0, 6, 2));
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        go_main(16'd12, 8'd32, 64'h001250, 1'b0);
        repeat (4) @(posedge clk);

        chk("main_pending_results", 112'(q_main.size()), 112'(0));
        chk("ov_pending_results", 112'(q_ov.size()), 112'(0));
        chk("wd_pending_results", 112'(q_wd.size()), 112'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/fixed_point_bcd_display.md
# fixed_point_bcd_display

Sequential fixed-point-to-decimal converter and seven-segment driver for the board display path, superseding the fixed 10.6 divide-based digit splitter. It accepts an unsigned integer part and a binary fraction on a start/done handshake. It converts the integer with iterative double-dabble and the fraction with repeated multiply-by-10. Digits and segment patterns are held in registers until the next conversion completes.

## Interface
- INT_W, 10: integer input width, ≥1
- FRAC_W, 6: fraction input width, ≥1; value = frac_in / 2^FRAC_W
- INT_DIGITS, 4: integer display digits, ≥1
- FRAC_DIGITS, 2: fraction display digits, ≥1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  conversion request; sampled only in IDLE
- int_in  in  INT_W  unsigned integer part
- frac_in  in  FRAC_W  binary fraction
- busy  out  1  high in INT and FRAC states
- done  out  1  one-cycle pulse; outputs updated
- overflow  out  1  last integer exceeded 10^INT_DIGITS−1
- digits_out  out  4*(INT_DIGITS+FRAC_DIGITS)  BCD; digit 0 = last fraction digit (LSB nibble), most significant integer digit in top nibble
- seg_out  out  7*(INT_DIGITS+FRAC_DIGITS)  active-low {g,f,e,d,c,b,a} per digit, same ordering

## Operation
- States: IDLE, INT, FRAC, DONE.
  - IDLE→INT on start=1: latch int_in and frac_in; clear BCD accumulator, step counter, and overflow_next (= int_in > 10^INT_DIGITS−1, constant computed at elaboration).
  - INT: one double-dabble step per cycle, MSB first: add 3 to each nibble ≥5, then shift left one bit. After INT_W steps → FRAC.
  - FRAC: one fraction digit per cycle, most significant first. p = frac·10 (FRAC_W+4 bits); digit = p[FRAC_W+3:FRAC_W]; frac = p[FRAC_W−1:0]. Truncating, no rounding. After FRAC_DIGITS steps → DONE, loading digits_out, seg_out and overflow.
  - DONE→IDLE unconditionally. done=1 only in DONE.
- Overflow: integer digits forced to all 9; fraction digits are still converted normally.
- BCD accumulator holds INT_DIGITS+1 nibbles, so the top digit never overflows mid-conversion.
- start while busy or in DONE: ignored, with no queueing. Input changes after the latch cycle have no effect.
- seg_out is a pure function of the registered digits_out, using the standard 0–9 decode. Values 10–15 cannot occur.
- Reset (asynchronous, any state, including mid-conversion): state=IDLE; busy=0, done=0, overflow=0; digits_out all 0; seg_out = decode of all-zero digits (7'b1000000 per digit, subject to the blanking rule). Any partial result is discarded.

## Timing
- Start sampled at edge k. First INT step at edge k+1, last FRAC step at edge k+INT_W+FRAC_DIGITS.
- done high for the cycle following that edge. Latency L = INT_W+FRAC_DIGITS edges (defaults: 12).
- Earliest next start accepted at edge k+L+2, giving a throughput of one conversion per L+2 cycles.
- busy rises the cycle after edge k and falls when DONE is entered.
- Outputs change only at the DONE-entry edge, and are stable for the whole done cycle and thereafter.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Integer digits above the most significant nonzero integer digit drive seg_out = 7'b1111111 (blank).
  - The integer ones digit and all fraction digits are never blanked.
  - digits_out is unaffected.
  - Blanking also applies to the reset value: only the integer ones digit and the fraction digits show "0".
- Undefined: every digit is always decoded, leading zeros included.

## Test plan
- Defaults; int_in=1023, frac_in=32 → digits 1,0,2,3 . 5,0; done exactly 12 edges after start; overflow=0.
- int_in=0, frac_in=1 → 0000.01. frac_in=63 → .98 (truncation, not .99). With LEADING_ZERO_BLANK_EN, seg for the three upper integer digits = 7'b1111111.
- INT_DIGITS=3, int_in=1023 → integer digits 9,9,9; overflow=1. A following conversion with int_in=5 clears overflow.
- start held high for 20 cycles, inputs changed mid-conversion → exactly one done per L+2 cycles; each result matches the value latched at its acceptance.
- rst low during FRAC of a conversion of 777.75 → immediate reset values, no done pulse. After release, a new start for 12.5 → 0012.50.
- INT_W=16, FRAC_W=8, INT_DIGITS=5, FRAC_DIGITS=3; int_in=65535, frac_in=255 → 65535.996; done after 19 edges.
